// File: rtl/air_cond_multizone.sv
// rtl/air_cond_multizone.sv - N-zone hysteresis heat/cool controller with minimum-dwell protection
module air_cond_multizone #(
    parameter int N_ZONES   = 4,
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int TARGET    = 20,
    parameter int COOL_ON   = 22,
    parameter int MIN_DWELL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [N_ZONES*TEMP_W-1:0]     temperature,
    input  logic [N_ZONES-1:0]            sensor_valid,
    output logic [N_ZONES-1:0]            heating,
    output logic [N_ZONES-1:0]            cooling,
    output logic                          any_heating,
    output logic                          any_cooling,
    output logic [$clog2(N_ZONES+1)-1:0]  heat_count,
    output logic [$clog2(N_ZONES+1)-1:0]  cool_count
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int CW = $clog2(N_ZONES + 1);

    localparam logic [TEMP_W-1:0] HEAT_ON_T = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] TARGET_T  = TEMP_W'(TARGET);
    localparam logic [TEMP_W-1:0] COOL_ON_T = TEMP_W'(COOL_ON);
    localparam logic [DW-1:0]     DWELL_LD  = DW'(MIN_DWELL - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEATING = 2'd1,
        COOLING = 2'd2
    } zone_state_t;

    zone_state_t         state_q [N_ZONES];
    zone_state_t         state_d [N_ZONES];
    logic [DW-1:0]       dwell_q [N_ZONES];
    logic [DW-1:0]       dwell_d [N_ZONES];
    logic [TEMP_W-1:0]   temp_z  [N_ZONES];

    logic                heat_allow;
    logic                cool_allow;
    logic [N_ZONES-1:0]  heat_next;
    logic [N_ZONES-1:0]  cool_next;
    logic [CW-1:0]       heat_cnt_next;
    logic [CW-1:0]       cool_cnt_next;

    assign heat_allow = mode[0];
    assign cool_allow = mode[1];

    // Split the flat temperature bus into per-zone samples
    for (genvar g = 0; g < N_ZONES; g++) begin : g_temp
        assign temp_z[g] = temperature[g*TEMP_W +: TEMP_W];
    end

    // Per-zone next state and dwell; mode-forced exits bypass the dwell hold
    always_comb begin
        for (int i = 0; i < N_ZONES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sensor_valid[i] && dwell_q[i] == '0) begin
                        if (heat_allow && temp_z[i] <= HEAT_ON_T) begin
                            state_d[i] = HEATING;
                        end else if (cool_allow && temp_z[i] >= COOL_ON_T) begin
                            state_d[i] = COOLING;
                        end
                    end
                end
                HEATING: begin
                    if (!heat_allow) begin
                        state_d[i] = IDLE;
                    end else if (sensor_valid[i] && dwell_q[i] == '0 && temp_z[i] >= TARGET_T) begin
                        state_d[i] = IDLE;
                    end
                end
                COOLING: begin
                    if (!cool_allow) begin
                        state_d[i] = IDLE;
                    end else if (sensor_valid[i] && dwell_q[i] == '0 && temp_z[i] <= TARGET_T) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            if (state_d[i] != state_q[i]) begin
                dwell_d[i] = DWELL_LD;
            end else if (dwell_q[i] != '0) begin
                dwell_d[i] = dwell_q[i] - DW'(1);
            end else begin
                dwell_d[i] = '0;
            end
        end
    end

    // Aggregates are derived from next state so they line up with heating/cooling
    always_comb begin
        heat_next     = '0;
        cool_next     = '0;
        heat_cnt_next = '0;
        cool_cnt_next = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            heat_next[i] = (state_d[i] == HEATING);
            cool_next[i] = (state_d[i] == COOLING);
            if (state_d[i] == HEATING) begin
                heat_cnt_next = heat_cnt_next + CW'(1);
            end
            if (state_d[i] == COOLING) begin
                cool_cnt_next = cool_cnt_next + CW'(1);
            end
        end
    end

    // Zone state and dwell registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ZONES; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                dwell_q[i] <= '0;
            end else begin
                state_q[i] <= state_d[i];
                dwell_q[i] <= dwell_d[i];
            end
        end
    end

    // Registered drive and summary outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            heating     <= '0;
            cooling     <= '0;
            any_heating <= 1'b0;
            any_cooling <= 1'b0;
            heat_count  <= '0;
            cool_count  <= '0;
        end else begin
            heating     <= heat_next;
            cooling     <= cool_next;
            any_heating <= |heat_next;
            any_cooling <= |cool_next;
            heat_count  <= heat_cnt_next;
            cool_count  <= cool_cnt_next;
        end
    end

endmodule

// File: tb/tb_air_cond_multizone.sv
// tb/tb_air_cond_multizone.sv - scoreboard bench for air_cond_multizone
module tb_air_cond_multizone;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic [19:0] temperature = {4{5'd20}};
    logic [3:0]  sensor_valid = 4'hF;
    logic [3:0]  heating;
    logic [3:0]  cooling;
    logic        any_heating;
    logic        any_cooling;
    logic [2:0]  heat_count;
    logic [2:0]  cool_count;

    logic [1:0]  mode1 = 2'b11;
    logic [4:0]  temp1 = 5'd20;
    logic [0:0]  valid1 = 1'b1;
    logic [0:0]  heating1;
    logic [0:0]  cooling1;
    logic        any_h1;
    logic        any_c1;
    logic [0:0]  hc1;
    logic [0:0]  cc1;

    int tests_run = 0;
    int fail_count = 0;

    logic [15:0] exp_q [$];
    logic [5:0]  exp1_q [$];

    always #5 clk = ~clk;

    air_cond_multizone dut (
        .clk(clk), .rst(rst), .mode(mode), .temperature(temperature),
        .sensor_valid(sensor_valid), .heating(heating), .cooling(cooling),
        .any_heating(any_heating), .any_cooling(any_cooling),
        .heat_count(heat_count), .cool_count(cool_count)
    );

    air_cond_multizone #(.N_ZONES(1), .MIN_DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .temperature(temp1),
        .sensor_valid(valid1), .heating(heating1), .cooling(cooling1),
        .any_heating(any_h1), .any_cooling(any_c1),
        .heat_count(hc1), .cool_count(cc1)
    );

    function automatic logic [15:0] mk_exp(input logic [3:0] h, input logic [3:0] c);
        return {h, c, |h, |c, 3'($countones(h)), 3'($countones(c))};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] want;
        logic [15:0] got;
        logic [5:0]  want1;
        logic [5:0]  got1;
        temperature = {4{5'd18}};
        temp1 = 5'd18;
        rst = 1'b1;
        exp_q.push_back(16'h0000);
        exp1_q.push_back(6'b000000);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                exp_q.push_back(16'h0000);
                exp1_q.push_back(6'b000000);
            end
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL reset[%0d] got=%h want=%h", k, got, want);
            end
            want1 = exp1_q.pop_front();
            got1 = {heating1, cooling1, any_h1, any_c1, hc1, cc1};
            tests_run++;
            if (got1 !== want1) begin
                fail_count++;
                $display("FAIL reset1[%0d] got=%b want=%b", k, got1, want1);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] want;
        logic [15:0] got;
        do_reset();
        mode = 2'b11;
        sensor_valid = 4'hF;
        temperature = {5'd19, 5'd20, 5'd22, 5'd18};
        exp_q.push_back(mk_exp(4'b0001, 4'b0010));
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
        tests_run++;
        if (got !== want) begin
            fail_count++;
            $display("FAIL basic got=%h want=%h", got, want);
        end
    endtask

    task automatic test_dwell();
        logic [15:0] want;
        logic [15:0] got;
        temperature = {5'd19, 5'd20, 5'd22, 5'd20};
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back((k < 4) ? mk_exp(4'b0001, 4'b0010) : mk_exp(4'b0000, 4'b0010));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL dwell[k+%0d] got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_mode_force();
        logic [15:0] want;
        logic [15:0] got;
        logic [1:0]  mseq [5] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [3:0]  cexp [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        sensor_valid = 4'hF;
        temperature = {5'd20, 5'd20, 5'd23, 5'd20};
        for (int k = 0; k < 5; k++) begin
            mode = mseq[k];
            exp_q.push_back(mk_exp(4'b0000, cexp[k]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL mode_force[%0d] got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_mode_gate();
        logic [15:0] want;
        logic [15:0] got;
        logic [1:0]  mseq [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
        logic [3:0]  hexp [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};
        logic [3:0]  cexp [4] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000};
        do_reset();
        sensor_valid = 4'hF;
        temperature = {5'd25, 5'd15, 5'd25, 5'd15};
        for (int k = 0; k < 4; k++) begin
            mode = mseq[k];
            exp_q.push_back(mk_exp(hexp[k], cexp[k]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL mode_gate[%0d] got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_invalid();
        logic [15:0] want;
        logic [15:0] got;
        do_reset();
        mode = 2'b11;
        temperature = {5'd20, 5'd15, 5'd20, 5'd20};
        for (int k = 0; k < 6; k++) begin
            sensor_valid = (k < 5) ? 4'b1011 : 4'b1111;
            exp_q.push_back((k < 5) ? mk_exp(4'b0000, 4'b0000) : mk_exp(4'b0100, 4'b0000));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL invalid[%0d] got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] want;
        logic [15:0] got;
        logic        rseq [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  hexp [4] = '{4'b0011, 4'b0011, 4'b0000, 4'b0011};
        do_reset();
        mode = 2'b11;
        sensor_valid = 4'hF;
        temperature = {5'd20, 5'd20, 5'd18, 5'd18};
        for (int k = 0; k < 4; k++) begin
            rst = rseq[k];
            exp_q.push_back(mk_exp(hexp[k], 4'b0000));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {heating, cooling, any_heating, any_cooling, heat_count, cool_count};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL reset_mid[%0d] got=%h want=%h", k, got, want);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_hysteresis();
        logic [5:0] want;
        logic [5:0] got;
        logic [4:0] tseq [9] = '{5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18};
        logic       hexp [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       cexp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        mode1 = 2'b11;
        valid1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            temp1 = tseq[k];
            exp1_q.push_back({hexp[k], cexp[k], hexp[k], cexp[k], hexp[k], cexp[k]});
            @(posedge clk);
            #1;
            want = exp1_q.pop_front();
            got = {heating1, cooling1, any_h1, any_c1, hc1, cc1};
            tests_run++;
            if (got !== want) begin
                fail_count++;
                $display("FAIL hysteresis[%0d] temp=%0d got=%b want=%b", k, tseq[k], got, want);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_dwell();
        test_mode_force();
        test_mode_gate();
        test_invalid();
        test_reset_mid();
        test_hysteresis();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
